// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared widths, defaults and types for the instruction fetch front end
package riscv_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEF = 32'd4;
  typedef enum logic {FETCH, FAULT} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 2-entry FIFO of fetch entries; r_e0 is always the head
module fetch_skid_buffer
  import riscv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_din,
  output logic [1:0]   o_count,
  output logic         o_valid,
  output fetch_entry_t o_head
);
  logic [1:0] r_count;
  fetch_entry_t r_e0, r_e1;
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_count <= 2'd0;
      r_e0 <= '0;
      r_e1 <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      if (i_pop & (r_count == 2'd2)) r_e0 <= r_e1;
      else if (i_push & (r_count == (i_pop ? 2'd1 : 2'd0))) r_e0 <= i_din;
      if (i_push & (r_count == (i_pop ? 2'd2 : 2'd1))) r_e1 <= i_din;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  assign o_count = r_count;
  assign o_valid = r_count != 2'd0;
  assign o_head = r_e0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues fetches to a registered instruction memory and
// buffers {pc, instruction} pairs for decode; redirects flush, misaligned ones fault
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] PC_STEP = PC_STEP_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            btn_reset_n,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instruction,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc
);
  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);
  fetch_state_e r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, r_inflight_pc, r_fault_pc;
  logic r_inflight;
  logic [1:0] w_count;
  logic [2:0] w_occ;
  logic w_pop, w_issue, w_push, w_aligned, w_misaligned, w_valid;
  fetch_entry_t w_head;
  assign w_pop = w_valid & out_ready;
  assign w_aligned = redirect_valid & (redirect_pc[1:0] == 2'b00);
  assign w_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
  // occupancy counts the in-flight word so the buffer can never overflow
  assign w_occ = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue = (r_state == FETCH) & !redirect_valid & (w_occ < DEPTH);
  assign w_push = r_inflight & !redirect_valid;
  always_ff @(posedge clk) begin
    if (!btn_reset_n) r_state <= FETCH;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = w_misaligned ? FAULT : w_aligned ? FETCH : r_state;
  end
  always_comb begin
    fetch_fault = r_state == FAULT;
  end
  always_ff @(posedge clk) begin
    if (!btn_reset_n) begin
      r_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_inflight_pc <= '0;
      r_fault_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
      r_pc <= w_aligned ? redirect_pc : w_issue ? r_pc + PC_STEP : r_pc;
      if (w_misaligned) r_fault_pc <= redirect_pc;
    end
  end
  fetch_skid_buffer u_buf (
    .clk     (clk),
    .i_rst_n (btn_reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_din   ('{pc: r_inflight_pc, instruction: imem_instruction}),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_head  (w_head)
  );
  assign imem_pc = r_pc;
  assign out_valid = w_valid;
  assign out_pc = w_head.pc;
  assign out_instruction = w_head.instruction;
  assign fault_pc = r_fault_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle checks of fetch_unit against a registered memory model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic btn_reset_n, redirect_valid, out_ready, out_valid, fetch_fault;
  logic [31:0] imem_pc, imem_instruction, redirect_pc, out_pc, out_instruction, fault_pc;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk              (clk),
    .btn_reset_n      (btn_reset_n),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_instruction  (out_instruction),
    .fetch_fault      (fetch_fault),
    .fault_pc         (fault_pc)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  always @(posedge clk) imem_instruction <= mem(imem_pc);
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_instr"}, out_instruction, 32'h0);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, "_fault_pc"}, fault_pc, 32'h0);
    chk({tag, "_imem_pc"}, imem_pc, 32'h0);
  endtask
  initial begin
    btn_reset_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    step;
    step;
    chk_reset_vals("rst");
    // stream with ready high
    btn_reset_n = 1'b1;
    chk("c0_valid", 32'(out_valid), 32'd0);
    step;
    chk("c1_valid", 32'(out_valid), 32'd0);
    step;
    chk("c2_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("stream_pc", out_pc, 32'(i * 4));
      chk("stream_instr", out_instruction, mem(32'(i * 4)));
      step;
    end
    // back-pressure for cycles 2..6
    btn_reset_n = 1'b0;
    out_ready = 1'b0;
    step;
    btn_reset_n = 1'b1;
    step;
    step;
    for (int i = 2; i < 7; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", out_pc, 32'h0);
      if (i < 6) step;
    end
    chk("stall_imem_pc", imem_pc, 32'h8);
    step;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("release_pc", out_pc, 32'(i * 4));
      chk("release_instr", out_instruction, mem(32'(i * 4)));
      step;
    end
    // redirect to 0x40 while 0x8 is popped
    btn_reset_n = 1'b0;
    step;
    btn_reset_n = 1'b1;
    step;
    step;
    step;
    step;
    chk("pre_redir_pc", out_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step;
    redirect_valid = 1'b0;
    chk("redir_t1_valid", 32'(out_valid), 32'd0);
    step;
    chk("redir_t2_valid", 32'(out_valid), 32'd0);
    step;
    chk("redir_t3_valid", 32'(out_valid), 32'd1);
    chk("redir_t3_pc", out_pc, 32'h40);
    chk("redir_t3_instr", out_instruction, mem(32'h40));
    step;
    chk("redir_t4_pc", out_pc, 32'h44);
    chk("redir_t4_imem_pc", imem_pc, 32'h4C);
    // misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step;
    redirect_valid = 1'b0;
    chk("fault_set", 32'(fetch_fault), 32'd1);
    chk("fault_pc", fault_pc, 32'h42);
    chk("fault_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step;
      chk("fault_hold_valid", 32'(out_valid), 32'd0);
      chk("fault_hold_imem_pc", imem_pc, 32'h4C);
      chk("fault_hold_fault", 32'(fetch_fault), 32'd1);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step;
    redirect_valid = 1'b0;
    chk("fault_clear", 32'(fetch_fault), 32'd0);
    chk("recover_t1_valid", 32'(out_valid), 32'd0);
    step;
    chk("recover_t2_valid", 32'(out_valid), 32'd0);
    step;
    chk("recover_t3_valid", 32'(out_valid), 32'd1);
    chk("recover_t3_pc", out_pc, 32'h80);
    chk("recover_t3_instr", out_instruction, mem(32'h80));
    // reset mid-stream with the buffer full
    out_ready = 1'b0;
    step;
    btn_reset_n = 1'b0;
    step;
    chk_reset_vals("midrst");
    out_ready = 1'b1;
    btn_reset_n = 1'b1;
    step;
    chk("restart_c1_valid", 32'(out_valid), 32'd0);
    step;
    chk("restart_c2_valid", 32'(out_valid), 32'd1);
    chk("restart_c2_pc", out_pc, 32'h0);
    // wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step;
    redirect_valid = 1'b0;
    step;
    step;
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr0", out_instruction, mem(32'hFFFF_FFFC));
    step;
    chk("wrap_pc1", out_pc, 32'h0);
    chk("wrap_instr1", out_instruction, mem(32'h0));
    step;
    chk("wrap_pc2", out_pc, 32'h4);
    chk("wrap_valid2", 32'(out_valid), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end sitting directly upstream of the instruction memory. Owns the program counter, presents fetch addresses to the memory, and captures the registered read data one cycle later. Delivers `{pc, instruction}` pairs to decode over a valid/ready handshake through a 2-entry buffer. Handles branch/jump redirects from execute, with a flush, and raises a sticky fault on misaligned redirect targets.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `PC_STEP`, default 4: sequential PC increment, in bytes.
- `BUF_DEPTH`, default 2: output buffer entries; fixed at 2 for full throughput.

- `clk`  in  1  single clock; all state updates on rising edge.
- `btn_reset_n`  in  1  synchronous, active-low reset.
- `imem_pc`  out  32  fetch address driven to instruction memory; equals internal `pc_q`.
- `imem_instruction`  in  32  memory read data; valid in the cycle after the address was presented.
- `redirect_valid`  in  1  one-cycle redirect request from execute.
- `redirect_pc`  in  32  redirect target.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_pc`  out  32  PC of the head entry.
- `out_instruction`  out  32  instruction of the head entry.
- `fetch_fault`  out  1  misaligned redirect seen; sticky.
- `fault_pc`  out  32  offending redirect target.

## Operation
- States: FETCH, FAULT.
- Internal state:
  - `pc_q`.
  - `inflight_q`: a fetch was issued last cycle.
  - `inflight_pc_q`.
  - Buffer `count_q`, range 0..2.
- `pop = out_valid & out_ready`.
- `issue = (state==FETCH) & !redirect_valid & (count_q + inflight_q - pop < 2)`.
- On issue:
  - `inflight_pc_q <= pc_q`.
  - `pc_q <= pc_q + PC_STEP`, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - `inflight_q <= 1`.
- Otherwise `inflight_q <= 0` and `pc_q` holds.
- When `inflight_q` is set, `{inflight_pc_q, imem_instruction}` is pushed into the buffer at the end of that cycle. Buffer order is FIFO.
- Aligned redirect (`redirect_pc[1:0]==0`):
  - Flush the buffer.
  - Kill the in-flight fetch; its push is suppressed.
  - `pc_q <= redirect_pc`.
  - No issue in this cycle.
  - A pop in the same cycle is still a completed transfer.
  - From FAULT, an aligned redirect clears `fetch_fault` and returns to FETCH.
- Misaligned redirect:
  - Flush the buffer and kill the in-flight fetch.
  - `fault_pc <= redirect_pc`, `fetch_fault <= 1`, enter FAULT.
- In FAULT: no issue, no push, `out_valid=0`. `imem_pc` holds its last value.
- Redirect has priority over push and issue in the same cycle.
- Handshake rule: while `out_valid & !out_ready`, `out_pc` and `out_instruction` stay stable. The only exception is a redirect, which may drop the entry.
- Reset (`btn_reset_n=0` at an edge), from any state including mid-stream:
  - `pc_q=RESET_PC`, `inflight_q=0`, `count_q=0`, state FETCH.
  - `out_valid=0`, `out_pc=0`, `out_instruction=0`.
  - `fetch_fault=0`, `fault_pc=0`.

## Timing
- `out_*` driven from buffer registers only; no combinational path from `imem_instruction` or `redirect_*` to `out_*`.
- After reset release (cycle 0 = first cycle with `btn_reset_n=1`):
  - `RESET_PC` is issued in cycle 0.
  - Data returns in cycle 1.
  - `out_valid=1` with `out_pc=RESET_PC` in cycle 2.
- Redirect in cycle t:
  - Target issued in t+1.
  - Data returns in t+2.
  - `out_valid` with `out_pc=redirect_pc` in t+3.
  - `out_valid=0` in t+1 and t+2.
- `fetch_fault` asserts in the cycle after the misaligned redirect.
- With `out_ready` held high, throughput is one instruction per cycle, with no bubbles after the initial latency.
- With `out_ready` low, at most 2 entries are buffered, and `count_q + inflight_q` never exceeds 2.

## Structure
- Shared package `riscv_fetch_pkg`:
  - `XLEN=32`.
  - Default `RESET_PC`.
  - `PC_STEP`.
  - Fetch state enum {FETCH, FAULT}.
  - Fetch entry struct {pc, instruction}.
- Sub-module `fetch_skid_buffer`: 2-entry FIFO of fetch entries with push, pop, flush, count, head outputs and synchronous active-low reset.
- The top level holds the PC, the in-flight tracking and the FSM.

## Test plan
- Reset then `out_ready=1` -> `out_valid` rises in cycle 2; `out_pc` = 0x0, 0x4, 0x8, 0xC on consecutive cycles; each `out_instruction` matches the memory word for its PC.
- `out_ready=0` from cycle 2 for 5 cycles -> `count_q=2`, issue stops, `out_pc` held at 0x0. Release -> 0x0, 0x4, 0x8… in order, with no duplicates or gaps.
- Redirect to 0x40 in cycle t with a simultaneous pop of 0x8 -> 0x8 counted as delivered; buffered and in-flight entries dropped; `out_valid=0` in t+1 and t+2; `out_pc=0x40` in t+3, then 0x44.
- Redirect to 0x42 -> `fetch_fault=1` and `fault_pc=0x42` next cycle; `out_valid=0` and no pushes for 10 cycles. Redirect to 0x80 -> fault clears and `out_pc=0x80` three cycles later.
- Reset asserted mid-stream with 2 entries buffered and one in flight -> next cycle all outputs at reset values; restart shows `out_pc=RESET_PC` in cycle 2 after release.
- Redirect to 0xFFFF_FFFC with `out_ready=1` -> `out_pc` = 0xFFFF_FFFC, then 0x0000_0000, then 0x0000_0004.
